// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//
// SAP-1 control unit. It decodes the one-hot T-state from the ring counter
// together with the IR opcode into the 12-bit control word that drives PC,
// MAR, RAM, IR, A, ALU, B and OUT. It also holds the halt latch and two sticky
// error flags: illegal opcode and non-one-hot T-state.
//
// Optional feature macro: CONTROL_SEQUENCER_ICOUNT_EN
//   When defined, a CNT_W-bit retired-instruction counter is built.
//   When undefined, instr_count is tied to zero and no counter flops exist.
//
// Parameters
//   CNT_W       width of the retired-instruction counter
//   HLT_OPCODE  opcode that halts the machine
//
// Ports
//   clk          in   system clock; all state updates on the rising edge
//                     (the ring counter advances on the falling edge)
//   reset        in   asynchronous, active-low reset
//   t_state      in   one-hot T-state, bit0 = T1 .. bit5 = T6
//   opcode       in   IR upper nibble
//   con          out  {Cp,Ep,Lm_n,CE_n,Li_n,Ei_n,La_n,Ea,Su,Eu,Lb_n,Lo_n}
//   halt         out  registered halt latch
//   illegal_op   out  sticky: undefined opcode decoded at T4
//   fault        out  sticky: t_state not one-hot at a rising edge
//   instr_count  out  retired-instruction count (zero without the macro)
// -----------------------------------------------------------------------------
module control_sequencer #(
    parameter int         CNT_W      = 16,
    parameter logic [3:0] HLT_OPCODE = 4'hF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       t_state,
    input  logic [3:0]       opcode,
    output logic [11:0]      con,
    output logic             halt,
    output logic             illegal_op,
    output logic             fault,
    output logic [CNT_W-1:0] instr_count
);

    // Control word bit positions
    localparam int CP   = 11;
    localparam int EP   = 10;
    localparam int LM_N = 9;
    localparam int CE_N = 8;
    localparam int LI_N = 7;
    localparam int EI_N = 6;
    localparam int LA_N = 5;
    localparam int EA   = 4;
    localparam int SU   = 3;
    localparam int EU   = 2;
    localparam int LB_N = 1;
    localparam int LO_N = 0;

    // All active-high strobes low, all active-low strobes high
    localparam logic [11:0] IDLE = 12'h3E3;

    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;

    logic        one_hot;
    logic        is_t4;
    logic        is_t6;
    logic        op_legal;
    logic [11:0] decoded;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero
    assign one_hot = (t_state != 6'd0) && ((t_state & (t_state - 6'd1)) == 6'd0);
    assign is_t4   = (t_state == T4);
    assign is_t6   = (t_state == T6);

    assign op_legal = (opcode == OP_LDA) || (opcode == OP_ADD) ||
                      (opcode == OP_SUB) || (opcode == OP_OUT) ||
                      (opcode == HLT_OPCODE);

    // Raw decode of T-state and opcode, before any halt/fault override
    always_comb begin
        decoded = IDLE;
        case (t_state)
            T1: begin
                decoded[EP]   = 1'b1;
                decoded[LM_N] = 1'b0;
            end
            T2: begin
                decoded[CP]   = 1'b1;
            end
            T3: begin
                decoded[CE_N] = 1'b0;
                decoded[LI_N] = 1'b0;
            end
            T4: begin
                // The halt opcode is checked first so a parameter value that
                // aliases another opcode still behaves as a halt.
                if (opcode != HLT_OPCODE) begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            decoded[EI_N] = 1'b0;
                            decoded[LM_N] = 1'b0;
                        end
                        OP_OUT: begin
                            decoded[EA]   = 1'b1;
                            decoded[LO_N] = 1'b0;
                        end
                        default: decoded = IDLE;
                    endcase
                end
            end
            T5: begin
                if (opcode != HLT_OPCODE) begin
                    case (opcode)
                        OP_LDA: begin
                            decoded[CE_N] = 1'b0;
                            decoded[LA_N] = 1'b0;
                        end
                        OP_ADD, OP_SUB: begin
                            decoded[CE_N] = 1'b0;
                            decoded[LB_N] = 1'b0;
                        end
                        default: decoded = IDLE;
                    endcase
                end
            end
            T6: begin
                if ((opcode != HLT_OPCODE) &&
                    ((opcode == OP_ADD) || (opcode == OP_SUB))) begin
                    decoded[EU]   = 1'b1;
                    decoded[LA_N] = 1'b0;
                    decoded[SU]   = (opcode == OP_SUB);
                end
            end
            default: decoded = IDLE;
        endcase
    end

    // Any abnormal condition parks the datapath: reset, halt, a latched fault,
    // or a malformed T-state seen right now (before it can be latched).
    always_comb begin
        if (!reset || halt || fault || !one_hot) begin
            con = IDLE;
        end else begin
            con = decoded;
        end
    end

    // Halt latch and sticky flags; only reset clears them
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            halt       <= 1'b0;
            illegal_op <= 1'b0;
            fault      <= 1'b0;
        end else begin
            if (is_t4 && (opcode == HLT_OPCODE)) begin
                halt <= 1'b1;
            end
            if (is_t4 && !op_legal) begin
                illegal_op <= 1'b1;
            end
            if (!one_hot) begin
                fault <= 1'b1;
            end
        end
    end

`ifdef CONTROL_SEQUENCER_ICOUNT_EN
    // An instruction retires at the end of T6 unless the machine is halted
    // or faulted; the halt instruction itself never reaches here un-halted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_count <= '0;
        end else if (is_t6 && !halt && !fault) begin
            instr_count <= instr_count + 1'b1;
        end
    end
`else
    assign instr_count = '0;
`endif

endmodule
